// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment display definitions: segment bit positions and the hex glyph table.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package seg7_scan_driver_pkg;

    // Bit positions inside the {dp,g,f,e,d,c,b,a} segment byte
    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high glyphs for nibbles 0..F (bit 0 = segment a)
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble + decimal point + blank flag to an active-high {dp,g..a} segment byte.
// Latency: combinational.
// Backpressure: none.
module seg7_hex_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    // Blanking only clears the glyph; the decimal point stays visible
    always_comb begin
        seg         = '0;
        seg[SEG_DP] = dp;
        if (!blank) begin
            seg[SEG_G:SEG_A] = hex_to_seg(nib);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display scanner with frame-aligned value updates and anti-ghost guard.
// Latency: 1 cycle from (tick, idx, display) state to pins; loads become visible at the next frame wrap.
// Backpressure: none; a load while one is pending overwrites the shadow (last load wins).
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int TICK_DIV       = 50000,
    parameter int GUARD          = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [7:0]        SEG_INV = {8{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_INV  = {DIGITS{AN_ACTIVE_LOW}};

    logic [TW-1:0]         tick;
    logic [IW-1:0]         idx;
    logic                  tick_last;
    logic                  idx_last;
    logic                  wrap;
    logic                  in_guard;

    logic [4*DIGITS-1:0]   shadow_value;
    logic [DIGITS-1:0]     shadow_dp;
    logic                  shadow_blz;
    logic [4*DIGITS-1:0]   disp_value;
    logic [DIGITS-1:0]     disp_dp;
    logic                  disp_blz;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [DIGITS-1:0]     an_sel;
    logic [7:0]            seg_pat;

    assign tick_last = (tick == TW'(TICK_DIV - 1));
    assign idx_last  = (idx == IW'(DIGITS - 1));
    assign wrap      = tick_last && idx_last;
    assign in_guard  = (int'(tick) < GUARD);

    // Slot tick and digit index; both wrap exactly at their terminal values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick <= '0;
            idx  <= '0;
        end else if (tick_last) begin
            tick <= '0;
            idx  <= idx_last ? '0 : idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // Shadow capture and frame-aligned promotion to the display registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blz   <= 1'b0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_blz     <= 1'b0;
            pending      <= 1'b0;
        end else if (load && wrap) begin
            disp_value   <= value;
            disp_dp      <= dp;
            disp_blz     <= blank_lz;
            pending      <= 1'b0;
        end else if (load) begin
            shadow_value <= value;
            shadow_dp    <= dp;
            shadow_blz   <= blank_lz;
            pending      <= 1'b1;
        end else if (wrap && pending) begin
            disp_value   <= shadow_value;
            disp_dp      <= shadow_dp;
            disp_blz     <= shadow_blz;
            pending      <= 1'b0;
        end
    end

    // Select the active digit and walk the leading-zero run from the most significant digit
    always_comb begin
        logic zero_run;
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_sel    = '0;
        zero_run  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            zero_run = zero_run && (disp_value[4*(DIGITS-k)-1 -: 4] == 4'h0);
            if (idx == IW'(k)) begin
                cur_nib                = disp_value[4*(DIGITS-k)-1 -: 4];
                cur_dp                 = disp_dp[DIGITS-1-k];
                cur_blank              = disp_blz && zero_run && (k != DIGITS - 1);
                an_sel[DIGITS-1-k]     = 1'b1;
            end
        end
    end

    seg7_hex_decode u_decode (
        .nib   (cur_nib),
        .dp    (cur_dp),
        .blank (cur_blank),
        .seg   (seg_pat)
    );

    // Registered pins; guard slots force everything to the inactive level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_out    <= SEG_INV;
            an_out     <= AN_INV;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= in_guard ? SEG_INV : (seg_pat ^ SEG_INV);
            an_out     <= in_guard ? AN_INV  : (an_sel ^ AN_INV);
            frame_done <= wrap;
        end
    end

endmodule
